// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI mode-0 slave bridging 32-bit frames onto a simple
// register bus. Frame layout, MSB first: [31] rd, [30:16] addr, [15:0] wdata.
// All SPI inputs are oversampled by clk through SYNC_STAGES flops.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   sclk, ss_n, mosi SPI inputs from the master (asynchronous to clk)
//   miso             SPI output to the master
//   reg_addr         register address, held between frames
//   reg_wr_en        one-clk write strobe, with reg_wdata
//   reg_wdata        write data, held between frames
//   reg_rd_en        one-clk read strobe
//   reg_rdata        read data, sampled the clk after reg_rd_en
//   frame_done       one-clk pulse per completed frame
//   frame_err        one-clk pulse per aborted frame
//
// state   | meaning
// IDLE    | ss_n high, waiting for ss_n falling edge
// CMD     | receiving rd flag and address (rising edges 0..15)
// DATA    | receiving write data / driving read data (rising edges 16..31)
// WAIT_SS | frame over or reset seen; ignore sclk until ss_n high
module spi_slave_regif #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic [14:0] reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wdata,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_WAIT_SS = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_q, ss_q;
  logic [1:0]             fill_cnt;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, sync_ok;

  logic [1:0]  state;
  logic [4:0]  bit_cnt;
  logic [14:0] rx_sr;
  logic [15:0] tx_sr;
  logic        rd_q;
  logic        rd_cap;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;
  assign ss_rise   = ss_s & ~ss_q;
  // The synchronizers come out of reset showing ss_n high; only trust the
  // sampled ss_n once the real pin value has propagated through every stage,
  // otherwise a reset with ss_n held low would look like a fresh frame start.
  assign sync_ok   = (fill_cnt == 2'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      fill_cnt  <= 2'd0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
      if (!sync_ok) fill_cnt <= fill_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT_SS;
      bit_cnt    <= 5'd0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      rd_q       <= 1'b0;
      rd_cap     <= 1'b0;
      miso       <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // reg_rdata is valid the clk after the read strobe
      rd_cap     <= reg_rd_en;
      if (rd_cap) tx_sr <= reg_rdata;

      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (ss_fall) begin
            state   <= ST_CMD;
            bit_cnt <= 5'd0;
            rx_sr   <= '0;
            rd_q    <= 1'b0;
          end
        end

        ST_CMD: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            miso      <= 1'b0;
            state     <= ST_IDLE;
          end else if (sclk_rise) begin
            rx_sr   <= {rx_sr[13:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              rd_q      <= rx_sr[14];
              reg_addr  <= {rx_sr[13:0], mosi_s};
              reg_rd_en <= rx_sr[14];
              state     <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            miso      <= 1'b0;
            state     <= ST_IDLE;
          end else if (sclk_rise) begin
            rx_sr   <= {rx_sr[13:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              if (!rd_q) begin
                reg_wr_en <= 1'b1;
                reg_wdata <= {rx_sr, mosi_s};
              end
              frame_done <= 1'b1;
              miso       <= 1'b0;
              state      <= ST_WAIT_SS;
            end
          end else if (sclk_fall && rd_q) begin
            // falling edges 15..30 present read data bits 15..0
            miso  <= tx_sr[15];
            tx_sr <= {tx_sr[14:0], 1'b0};
          end
        end

        ST_WAIT_SS: begin
          miso <= 1'b0;
          if (sync_ok && ss_s) state <= ST_IDLE;
        end

        default: state <= ST_WAIT_SS;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Testbench for spi_slave_regif: drives SPI frames from a table, predicts
// register-bus strobes into scoreboard queues, and checks them as they appear.
module tb_spi_slave_regif;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, ss_n, mosi;
  logic        miso;
  logic [14:0] reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wdata;
  logic        reg_rd_en;
  logic [15:0] reg_rdata;
  logic        frame_done, frame_err;

  spi_slave_regif #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wdata  (reg_wdata),
    .reg_rd_en  (reg_rd_en),
    .reg_rdata  (reg_rdata),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    logic [15:0] rdata;
    int          gap;
    int          exp_wr;
    int          exp_rd;
    int          exp_done;
    int          exp_err;
    logic [31:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  int n_pass = 0;
  int n_total = 0;

  wr_t         wr_q[$];
  logic [14:0] rd_q[$];

  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, miso_cnt = 0;

  logic [14:0] model_addr;
  logic [15:0] model_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: strobes are compared against predictions as they occur.
  always @(negedge clk) begin
    if (!rst) begin
      if (miso) miso_cnt++;
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (reg_wr_en && reg_rd_en) chk("wr_rd_same_clk", 32'd1, 32'd0);
      if (reg_wr_en) begin
        wr_t e;
        wr_cnt++;
        if (wr_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", {17'd0, reg_addr}, {17'd0, e.addr});
          chk("wr_data", {16'd0, reg_wdata}, {16'd0, e.data});
        end
      end
      if (reg_rd_en) begin
        logic [14:0] a;
        rd_cnt++;
        if (rd_q.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
        else begin
          a = rd_q.pop_front();
          chk("rd_addr", {17'd0, reg_addr}, {17'd0, a});
        end
      end
    end
  end

  // One SPI mode-0 frame; optional reset pulse at the start of bit rst_at.
  task automatic spi_frame(input logic [31:0] w, input int nbits, input int rst_at,
                           output logic [31:0] rx);
    rx = '0;
    ss_n = 1'b0;
    wclk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
      end
      mosi = (i < 32) ? w[31 - i] : 1'b0;
      wclk(4);
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      wclk(8);
      sclk = 1'b0;
      wclk(4);
    end
    wclk(8);
    mosi = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] rx;
    int wr0, rd0, dn0, er0, mi0;
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt; mi0 = miso_cnt;
    reg_rdata = v.rdata;
    if (v.exp_wr != 0) wr_q.push_back('{addr: v.word[30:16], data: v.word[15:0]});
    if (v.exp_rd != 0) rd_q.push_back(v.word[30:16]);
    if (v.nbits >= 16) model_addr = v.word[30:16];
    if (v.exp_wr != 0) model_wdata = v.word[15:0];
    spi_frame(v.word, v.nbits, -1, rx);
    ss_n = 1'b1;
    wclk(v.gap);
    chk({tag, "_wr_cnt"}, wr_cnt - wr0, v.exp_wr);
    chk({tag, "_rd_cnt"}, rd_cnt - rd0, v.exp_rd);
    chk({tag, "_done_cnt"}, done_cnt - dn0, v.exp_done);
    chk({tag, "_err_cnt"}, err_cnt - er0, v.exp_err);
    chk({tag, "_addr_hold"}, {17'd0, reg_addr}, {17'd0, model_addr});
    chk({tag, "_wdata_hold"}, {16'd0, reg_wdata}, {16'd0, model_wdata});
    if (v.nbits == 32) chk({tag, "_miso_rx"}, rx, v.exp_rx);
    if (v.exp_rd == 0) chk({tag, "_miso_quiet"}, miso_cnt - mi0, 0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] rx;
    int wr0, rd0, dn0, er0;

    //        word          nbits rdata     gap wr rd done err exp_rx
    vecs[0] = '{32'h0012ABCD, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0000_0000};
    vecs[1] = '{32'h80340000, 32, 16'h5A5A, 10, 0, 1, 1, 0, 32'h0000_5A5A};
    vecs[2] = '{32'h00011111, 20, 16'h0000, 10, 0, 0, 0, 1, 32'h0000_0000};
    vecs[3] = '{32'h00022222, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0000_0000};
    vecs[4] = '{32'h00010001, 32, 16'h0000,  3, 1, 0, 1, 0, 32'h0000_0000};
    vecs[5] = '{32'h00020002, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0000_0000};
    vecs[6] = '{32'hFFFF0000, 32, 16'h8001, 10, 0, 1, 1, 0, 32'h0000_8001};
    vecs[7] = '{32'h7FFFFFFF, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0000_0000};

    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; reg_rdata = '0;
    model_addr = '0; model_wdata = '0;
    wclk(3);
    rst = 1'b0;
    wclk(100);
    chk("idle_miso", {31'd0, miso}, 32'd0);
    chk("idle_addr", {17'd0, reg_addr}, 32'd0);
    chk("idle_wdata", {16'd0, reg_wdata}, 32'd0);
    chk("idle_strobes", wr_cnt + rd_cnt + done_cnt + err_cnt, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a frame with ss_n held low for 40 sclk cycles.
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt;
    reg_rdata = 16'hFFFF;
    spi_frame(32'h00445566, 40, 10, rx);
    model_addr = '0; model_wdata = '0;
    chk("rst_mid_strobes", (wr_cnt - wr0) + (rd_cnt - rd0) + (done_cnt - dn0) + (err_cnt - er0), 0);
    chk("rst_mid_addr", {17'd0, reg_addr}, 32'd0);
    chk("rst_mid_miso", {31'd0, miso}, 32'd0);
    ss_n = 1'b1;
    wclk(10);
    run_vec('{32'h00330044, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0}, "post_rst");

    // Read immediately followed by a write with a short gap.
    run_vec('{32'h80050000, 32, 16'h1234, 3, 0, 1, 1, 0, 32'h0000_1234}, "b2b_rd");
    run_vec('{32'h0006BEEF, 32, 16'h0000, 10, 1, 0, 1, 0, 32'h0}, "b2b_wr");

    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
